// File: rtl/mips_bus_arbiter.sv
`default_nettype none
// ============================================================================
// mips_bus_arbiter : round-robin N-port MIPS load/store arbiter onto Avalon-MM
// Rev 1.0
// ============================================================================
module mips_bus_arbiter #(
  parameter int N_PORTS = 2,
  parameter int TIMEOUT = 255
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [N_PORTS-1:0]    p_req,
  input  logic [N_PORTS-1:0]    p_we,
  input  logic [2*N_PORTS-1:0]  p_size,
  input  logic [N_PORTS-1:0]    p_sign,
  input  logic [32*N_PORTS-1:0] p_addr,
  input  logic [32*N_PORTS-1:0] p_wdata,
  output logic [N_PORTS-1:0]    p_ack,
  output logic                  p_err,
  output logic [31:0]           p_rdata,
  output logic [31:0]           address,
  output logic                  write,
  output logic                  read,
  output logic [31:0]           writedata,
  output logic [3:0]            byteenable,
  input  logic                  waitrequest,
  input  logic [31:0]           readdata
);

  localparam logic [15:0] c_TMO_LAST = 16'(TIMEOUT - 1);
  localparam logic [2:0]  c_LAST_RST = 3'(N_PORTS - 1);

  typedef logic [N_PORTS-1:0] port_vec_t;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_RESP   = 2'd2
  } state_t;

  state_t      r_state;
  logic [2:0]  r_last;
  logic [2:0]  r_gnt;
  logic        r_we;
  logic        r_sign;
  logic [1:0]  r_size;
  logic [1:0]  r_lane;
  logic [15:0] r_stall;

  // Ports are zero-padded to 8 so a 3-bit index always selects exactly.
  logic [7:0]   w_req8;
  logic [7:0]   w_we8;
  logic [7:0]   w_sign8;
  logic [15:0]  w_size16;
  logic [255:0] w_addr256;
  logic [255:0] w_wdata256;

  logic        w_gnt_vld;
  logic [2:0]  w_gnt_idx;
  logic        w_g_we;
  logic        w_g_sign;
  logic [1:0]  w_g_size;
  logic [31:0] w_g_addr;
  logic [31:0] w_g_wdata;
  logic        w_g_legal;
  logic [3:0]  w_g_be;
  logic [31:0] w_g_wd;
  logic [7:0]  w_rd_byte;
  logic [15:0] w_rd_half;
  logic [31:0] w_rd_ext;

  assign w_req8     = 8'(p_req);
  assign w_we8      = 8'(p_we);
  assign w_sign8    = 8'(p_sign);
  assign w_size16   = 16'(p_size);
  assign w_addr256  = 256'(p_addr);
  assign w_wdata256 = 256'(p_wdata);

  // Scan from farthest to nearest so the port right after last_grant wins.
  always_comb begin
    w_gnt_vld = 1'b0;
    w_gnt_idx = 3'd0;
    for (int k = N_PORTS; k >= 1; k--) begin
      if (w_req8[3'((int'(r_last) + k) % N_PORTS)]) begin
        w_gnt_vld = 1'b1;
        w_gnt_idx = 3'((int'(r_last) + k) % N_PORTS);
      end
    end
  end

  assign w_g_we    = w_we8[w_gnt_idx];
  assign w_g_sign  = w_sign8[w_gnt_idx];
  assign w_g_size  = w_size16[{w_gnt_idx, 1'b0} +: 2];
  assign w_g_addr  = w_addr256[{w_gnt_idx, 5'b00000} +: 32];
  assign w_g_wdata = w_wdata256[{w_gnt_idx, 5'b00000} +: 32];

  always_comb begin
    w_g_legal = 1'b1;
    w_g_be    = 4'b0000;
    w_g_wd    = w_g_wdata;
    case (w_g_size)
      2'b00: begin
        w_g_be = 4'b0001 << w_g_addr[1:0];
        w_g_wd = {4{w_g_wdata[7:0]}};
      end
      2'b01: begin
        w_g_be    = w_g_addr[1] ? 4'b1100 : 4'b0011;
        w_g_wd    = {2{w_g_wdata[15:0]}};
        w_g_legal = ~w_g_addr[0];
      end
      2'b10: begin
        w_g_be    = 4'b1111;
        w_g_legal = (w_g_addr[1:0] == 2'b00);
      end
      default: w_g_legal = 1'b0;
    endcase
  end

  assign w_rd_byte = readdata[{r_lane, 3'b000} +: 8];
  assign w_rd_half = r_lane[1] ? readdata[31:16] : readdata[15:0];

  always_comb begin
    w_rd_ext = readdata;
    case (r_size)
      2'b00:   w_rd_ext = {{24{r_sign & w_rd_byte[7]}}, w_rd_byte};
      2'b01:   w_rd_ext = {{16{r_sign & w_rd_half[15]}}, w_rd_half};
      default: w_rd_ext = readdata;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= S_IDLE;
      r_last     <= c_LAST_RST;
      r_gnt      <= 3'd0;
      r_we       <= 1'b0;
      r_sign     <= 1'b0;
      r_size     <= 2'b00;
      r_lane     <= 2'b00;
      r_stall    <= 16'd0;
      read       <= 1'b0;
      write      <= 1'b0;
      address    <= 32'd0;
      writedata  <= 32'd0;
      byteenable <= 4'b0000;
      p_ack      <= '0;
      p_err      <= 1'b0;
      p_rdata    <= 32'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_gnt_vld) begin
            r_gnt   <= w_gnt_idx;
            r_we    <= w_g_we;
            r_sign  <= w_g_sign;
            r_size  <= w_g_size;
            r_lane  <= w_g_addr[1:0];
            r_stall <= 16'd0;
            if (w_g_legal) begin
              r_state    <= S_ACCESS;
              address    <= {w_g_addr[31:2], 2'b00};
              writedata  <= w_g_wd;
              byteenable <= w_g_be;
              read       <= ~w_g_we;
              write      <= w_g_we;
            end else begin
              r_state <= S_RESP;
              p_ack   <= port_vec_t'(8'd1 << w_gnt_idx);
              p_err   <= 1'b1;
            end
          end
        end
        S_ACCESS: begin
          if (!waitrequest) begin
            read    <= 1'b0;
            write   <= 1'b0;
            r_state <= S_RESP;
            p_ack   <= port_vec_t'(8'd1 << r_gnt);
            p_rdata <= r_we ? 32'd0 : w_rd_ext;
          end else if (r_stall == c_TMO_LAST) begin
            // Abort: the bus cycle is dropped and p_rdata stays zero.
            read    <= 1'b0;
            write   <= 1'b0;
            r_state <= S_RESP;
            p_ack   <= port_vec_t'(8'd1 << r_gnt);
            p_err   <= 1'b1;
          end else begin
            r_stall <= r_stall + 16'd1;
          end
        end
        S_RESP: begin
          p_ack   <= '0;
          p_err   <= 1'b0;
          p_rdata <= 32'd0;
          r_last  <= r_gnt;
          r_stall <= 16'd0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mips_bus_arbiter.sv
`default_nettype none
// ============================================================================
// tb_mips_bus_arbiter : scoreboard bench, directed vectors for mips_bus_arbiter
// Rev 1.0
// ============================================================================
module tb_mips_bus_arbiter;

  localparam int NP = 2;

  logic            clk = 1'b0;
  logic            reset;
  logic [NP-1:0]   p_req;
  logic [NP-1:0]   p_we;
  logic [2*NP-1:0] p_size;
  logic [NP-1:0]   p_sign;
  logic [32*NP-1:0] p_addr;
  logic [32*NP-1:0] p_wdata;
  logic [NP-1:0]   p_ack;
  logic            p_err;
  logic [31:0]     p_rdata;
  logic [31:0]     address;
  logic            write;
  logic            read;
  logic [31:0]     writedata;
  logic [3:0]      byteenable;
  logic            waitrequest = 1'b0;
  logic [31:0]     readdata;

  logic [NP-1:0]   req_t4;
  logic            wait_t4 = 1'b1;
  logic [NP-1:0]   ack_t4;
  logic            err_t4;
  logic [31:0]     rdata_t4;
  logic [31:0]     addr_t4;
  logic            wr_t4;
  logic            rd_t4;
  logic [31:0]     wd_t4;
  logic [3:0]      be_t4;

  mips_bus_arbiter #(.N_PORTS(NP), .TIMEOUT(255)) u_dut (
    .clk(clk), .reset(reset),
    .p_req(p_req), .p_we(p_we), .p_size(p_size), .p_sign(p_sign),
    .p_addr(p_addr), .p_wdata(p_wdata),
    .p_ack(p_ack), .p_err(p_err), .p_rdata(p_rdata),
    .address(address), .write(write), .read(read),
    .writedata(writedata), .byteenable(byteenable),
    .waitrequest(waitrequest), .readdata(readdata)
  );

  mips_bus_arbiter #(.N_PORTS(NP), .TIMEOUT(4)) u_dut_t4 (
    .clk(clk), .reset(reset),
    .p_req(req_t4), .p_we(p_we), .p_size(p_size), .p_sign(p_sign),
    .p_addr(p_addr), .p_wdata(p_wdata),
    .p_ack(ack_t4), .p_err(err_t4), .p_rdata(rdata_t4),
    .address(addr_t4), .write(wr_t4), .read(rd_t4),
    .writedata(wd_t4), .byteenable(be_t4),
    .waitrequest(wait_t4), .readdata(readdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    string         tag;
    logic [NP-1:0] ack;
    logic          err;
    logic          chk_rd;
    logic [31:0]   rdata;
  } rsp_t;

  typedef struct {
    string       tag;
    logic [31:0] addr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wd;
    int          len;
  } bus_t;

  rsp_t q_rsp[$];
  bus_t q_bus[$];
  rsp_t m_rsp;
  bus_t m_bus;

  int n_chk = 0;
  int n_pass = 0;
  int n_ack_seen = 0;
  int stall_cfg = 0;
  int acc_cnt = 0;
  int b_len = 0;
  bit b_act = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // Avalon slave model: hold waitrequest for stall_cfg cycles of each access.
  always @(negedge clk) begin
    if (read || write) begin
      waitrequest = (acc_cnt < stall_cfg);
      acc_cnt++;
    end else begin
      waitrequest = 1'b0;
      acc_cnt = 0;
    end
  end

  always @(negedge clk) begin
    if (|p_ack) begin
      n_ack_seen++;
      if (q_rsp.size() == 0) begin
        n_chk++;
        $display("FAIL rsp_unexpected: p_ack=%b with no response pending", p_ack);
      end else begin
        m_rsp = q_rsp.pop_front();
        check({m_rsp.tag, "_ack"}, 64'(p_ack), 64'(m_rsp.ack));
        check({m_rsp.tag, "_err"}, 64'(p_err), 64'(m_rsp.err));
        if (m_rsp.chk_rd) check({m_rsp.tag, "_rdata"}, 64'(p_rdata), 64'(m_rsp.rdata));
      end
    end
  end

  always @(negedge clk) begin
    if (read || write) begin
      if (!b_act) begin
        b_act = 1'b1;
        b_len = 1;
        if (q_bus.size() == 0) begin
          n_chk++;
          $display("FAIL bus_unexpected: read=%b write=%b address=0x%0h", read, write, address);
          m_bus = '{tag: "unexp", addr: 32'd0, we: 1'b0, be: 4'd0, wd: 32'd0, len: -1};
        end else begin
          m_bus = q_bus.pop_front();
          check({m_bus.tag, "_addr"}, 64'(address), 64'(m_bus.addr));
          check({m_bus.tag, "_dir"}, 64'({write, read}), 64'({m_bus.we, ~m_bus.we}));
          check({m_bus.tag, "_be"}, 64'(byteenable), 64'(m_bus.be));
          check({m_bus.tag, "_wd"}, 64'(writedata), 64'(m_bus.wd));
        end
      end else begin
        b_len++;
      end
    end else if (b_act) begin
      b_act = 1'b0;
      check({m_bus.tag, "_len"}, 64'(b_len), 64'(m_bus.len));
    end
  end

  task automatic set_port(input int port, input bit we, input logic [1:0] size, input bit sign,
                          input logic [31:0] addr, input logic [31:0] wdata);
    p_we[port]               = we;
    p_size[2*port +: 2]      = size;
    p_sign[port]             = sign;
    p_addr[32*port +: 32]    = addr;
    p_wdata[32*port +: 32]   = wdata;
  endtask

  task automatic wait_ack(input int port, input int limit, output int lat);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!p_ack[port] && lat < limit);
    if (!p_ack[port]) begin
      n_chk++;
      $display("FAIL ack_timeout: port %0d got no p_ack within %0d cycles", port, limit);
    end
  endtask

  // One single-port transaction; expected latency counts the request cycle as 1.
  task automatic xact(input string tag, input int port, input bit we, input logic [1:0] size,
                      input bit sign, input logic [31:0] addr, input logic [31:0] wdata,
                      input logic [31:0] rd_bus, input int stall, input bit bad,
                      input logic [31:0] e_addr, input logic [3:0] e_be,
                      input logic [31:0] e_wd, input logic [31:0] e_rdata);
    logic [NP-1:0] oh;
    int lat;
    oh = '0;
    oh[port] = 1'b1;
    q_rsp.push_back('{tag: tag, ack: oh, err: bad, chk_rd: (!we && !bad), rdata: e_rdata});
    if (!bad) q_bus.push_back('{tag: tag, addr: e_addr, we: we, be: e_be, wd: e_wd, len: stall + 1});
    set_port(port, we, size, sign, addr, wdata);
    readdata  = rd_bus;
    stall_cfg = stall;
    p_req[port] = 1'b1;
    wait_ack(port, 40, lat);
    check({tag, "_lat"}, 64'(lat), bad ? 64'd2 : 64'(3 + stall));
    p_req[port] = 1'b0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int got;
    int cyc;
    int rdc;
    int wrc;
    int base;
    reset = 1'b0;
    p_req = '0; req_t4 = '0; p_we = '0; p_size = '0; p_sign = '0;
    p_addr = '0; p_wdata = '0; readdata = 32'd0;

    repeat (2) @(negedge clk);
    check("rst_strobe", 64'({read, write}), 64'd0);
    check("rst_addr",   64'(address),       64'd0);
    check("rst_wd",     64'(writedata),     64'd0);
    check("rst_be",     64'(byteenable),    64'd0);
    check("rst_ack",    64'(p_ack),         64'd0);
    check("rst_err",    64'(p_err),         64'd0);
    check("rst_rdata",  64'(p_rdata),       64'd0);
    @(posedge clk);
    #1 reset = 1'b1;

    //    tag     port we size  sg addr          wdata          readdata       st bad e_addr        e_be     e_wd           e_rdata
    xact("r031",  1, 0, 2'b00, 1, 32'h0000_1003, 32'h0,         32'h80FF_FF11, 0, 0, 32'h0000_1000, 4'b1000, 32'h0,         32'hFFFF_FF80);
    xact("w032",  0, 1, 2'b01, 0, 32'h0000_2002, 32'h0000_ABCD, 32'h0,         4, 0, 32'h0000_2000, 4'b1100, 32'hABCD_ABCD, 32'h0);
    xact("e034",  0, 0, 2'b10, 0, 32'h0000_0006, 32'h0,         32'h0,         0, 1, 32'h0,         4'b0000, 32'h0,         32'h0);
    xact("rhs",   1, 0, 2'b01, 1, 32'h0000_3002, 32'h0,         32'h8001_7FFF, 0, 0, 32'h0000_3000, 4'b1100, 32'h0,         32'hFFFF_8001);
    xact("rhu",   0, 0, 2'b01, 0, 32'h0000_3000, 32'h0,         32'h8001_F00F, 0, 0, 32'h0000_3000, 4'b0011, 32'h0,         32'h0000_F00F);
    xact("rw",    1, 0, 2'b10, 1, 32'h0000_4000, 32'h0,         32'hDEAD_BEEF, 0, 0, 32'h0000_4000, 4'b1111, 32'h0,         32'hDEAD_BEEF);
    xact("wb",    0, 1, 2'b00, 0, 32'h0000_5001, 32'h0000_005A, 32'h0,         1, 0, 32'h0000_5000, 4'b0010, 32'h5A5A_5A5A, 32'h0);
    xact("esz",   1, 0, 2'b11, 0, 32'h0000_8000, 32'h0,         32'h0,         0, 1, 32'h0,         4'b0000, 32'h0,         32'h0);
    xact("rbu",   0, 0, 2'b00, 0, 32'h0000_0010, 32'h0,         32'h1234_5681, 0, 0, 32'h0000_0010, 4'b0001, 32'h0,         32'h0000_0081);
    xact("rbs1",  0, 0, 2'b00, 1, 32'h0000_0021, 32'h0,         32'h0000_7F00, 0, 0, 32'h0000_0020, 4'b0010, 32'h0,         32'h0000_007F);
    xact("ehm",   0, 0, 2'b01, 0, 32'h0000_9001, 32'h0,         32'h0,         0, 1, 32'h0,         4'b0000, 32'h0,         32'h0);
    xact("ww",    1, 1, 2'b10, 0, 32'h0000_A004, 32'hCAFE_F00D, 32'h0,         0, 0, 32'h0000_A004, 4'b1111, 32'hCAFE_F00D, 32'h0);

    // Both ports requesting continuously from reset: 0,1,0,1 at 3 cycles each.
    reset = 1'b0;
    @(posedge clk);
    #1 reset = 1'b1;
    set_port(0, 0, 2'b10, 0, 32'h0000_0100, 32'h0);
    set_port(1, 0, 2'b00, 0, 32'h0000_0202, 32'h0);
    readdata  = 32'h1122_3344;
    stall_cfg = 0;
    for (int i = 0; i < 2; i++) begin
      q_rsp.push_back('{tag: "rr0", ack: 2'b01, err: 1'b0, chk_rd: 1'b1, rdata: 32'h1122_3344});
      q_bus.push_back('{tag: "rr0", addr: 32'h0000_0100, we: 1'b0, be: 4'b1111, wd: 32'h0, len: 1});
      q_rsp.push_back('{tag: "rr1", ack: 2'b10, err: 1'b0, chk_rd: 1'b1, rdata: 32'h0000_0022});
      q_bus.push_back('{tag: "rr1", addr: 32'h0000_0200, we: 1'b0, be: 4'b0100, wd: 32'h0, len: 1});
    end
    p_req = 2'b11;
    got = 0;
    cyc = 0;
    while (got < 4 && cyc < 40) begin
      @(negedge clk);
      cyc++;
      if (|p_ack) got++;
    end
    p_req = 2'b00;
    check("rr_ack_count", 64'(got), 64'd4);
    check("rr_cycles",    64'(cyc), 64'd12);
    @(posedge clk);
    #1;

    // Reset pulsed while a write is stalled in ACCESS.
    q_bus.push_back('{tag: "arst", addr: 32'h0000_0040, we: 1'b1, be: 4'b1111, wd: 32'h0000_0001, len: 2});
    set_port(0, 1, 2'b10, 0, 32'h0000_0040, 32'h0000_0001);
    stall_cfg = 100;
    p_req[0] = 1'b1;
    repeat (3) @(posedge clk);
    #2;
    reset = 1'b0;
    p_req = 2'b00;
    #1;
    check("arst_strobe", 64'({read, write}), 64'd0);
    check("arst_addr",   64'(address),       64'd0);
    check("arst_wd",     64'(writedata),     64'd0);
    check("arst_be",     64'(byteenable),    64'd0);
    check("arst_ack",    64'({p_ack, p_err}), 64'd0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    stall_cfg = 0;
    base = n_ack_seen;
    repeat (8) @(negedge clk);
    check("arst_no_ack", 64'(n_ack_seen), 64'(base));

    // TIMEOUT=4 instance with waitrequest stuck high.
    set_port(0, 0, 2'b00, 1, 32'h0000_0007, 32'h0);
    readdata = 32'hFFFF_FFFF;
    @(posedge clk);
    #1 req_t4 = 2'b01;
    rdc = 0;
    wrc = 0;
    cyc = 0;
    while (cyc < 20) begin
      @(negedge clk);
      cyc++;
      if (rd_t4) begin
        if (rdc == 0) begin
          check("t4_addr", 64'(addr_t4), 64'h4);
          check("t4_be",   64'(be_t4),   64'b1000);
          check("t4_wd",   64'(wd_t4),   64'd0);
        end
        rdc++;
      end
      if (wr_t4) wrc++;
      if (|ack_t4) break;
    end
    req_t4 = 2'b00;
    check("t4_ack",       64'(ack_t4),   64'b01);
    check("t4_err",       64'(err_t4),   64'd1);
    check("t4_rdata",     64'(rdata_t4), 64'd0);
    check("t4_rd_cycles", 64'(rdc),      64'd4);
    check("t4_wr_cycles", 64'(wrc),      64'd0);
    check("t4_lat",       64'(cyc),      64'd6);

    repeat (4) @(negedge clk);
    check("rsp_queue_empty", 64'(q_rsp.size()), 64'd0);
    check("bus_queue_empty", 64'(q_bus.size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mips_bus_arbiter.md
MIPS_BUS_ARBITER -- requirements
Module: mips_bus_arbiter

Interface
REQ-001 Parameter N_PORTS, default 2, SHALL set the number of requester ports (legal range 1..8).
REQ-002 Parameter TIMEOUT, default 255, SHALL set the maximum number of waitrequest-stalled ACCESS cycles before abort (legal range 1..65535).
REQ-003 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 p_req  input  N_PORTS  per-port request; held high until p_ack.
REQ-006 p_we  input  N_PORTS  per-port write (1) / read (0).
REQ-007 p_size  input  2*N_PORTS  per-port size: 00 byte, 01 half, 10 word; 11 is illegal.
REQ-008 p_sign  input  N_PORTS  per-port sign-extend on reads.
REQ-009 p_addr  input  32*N_PORTS  per-port byte address.
REQ-010 p_wdata  input  32*N_PORTS  per-port write data, right-aligned.
REQ-011 p_ack  output  N_PORTS  one-cycle completion pulse to the granted port.
REQ-012 p_err  output  1  qualifies p_ack: misaligned, illegal size or timeout.
REQ-013 p_rdata  output  32  extended read data, valid while any p_ack bit is high.
REQ-014 address, write, read, writedata[31:0], byteenable[3:0]  outputs; waitrequest, readdata[31:0]  inputs  Avalon-MM master.

Function
REQ-015 The FSM SHALL have states IDLE, ACCESS and RESP.
REQ-016 In IDLE with any p_req high, the block SHALL grant one port round-robin, starting the search at (last_grant+1) mod N_PORTS, and SHALL latch that port's we/size/sign/addr/wdata.
REQ-017 Legality SHALL be checked at grant: size 11, half with addr[0]=1, or word with addr[1:0]!=00 SHALL go directly to RESP with p_err=1 and no bus cycle.
REQ-018 A legal grant SHALL move to ACCESS; read or write SHALL be high throughout ACCESS, with address = {latched addr[31:2], 2'b00}.
REQ-019 byteenable: byte -> 4'b0001 << addr[1:0]; half -> addr[1] ? 1100 : 0011; word -> 1111.
REQ-020 writedata: byte -> data[7:0] replicated on all four lanes; half -> data[15:0] replicated twice; word -> data unchanged.
REQ-021 ACCESS SHALL complete on the first rising edge where waitrequest=0; on a read, readdata SHALL be captured at that edge.
REQ-022 A stall counter SHALL count ACCESS edges with waitrequest=1; on reaching TIMEOUT the block SHALL drop read/write, go to RESP with p_err=1, and leave p_rdata at 0.
REQ-023 Captured read data SHALL be extracted from the addressed lane (byte: addr[1:0], half: addr[1]) and zero- or sign-extended per the latched sign.
REQ-024 RESP SHALL last exactly one cycle, with p_ack set only on the granted bit; the FSM SHALL then return to IDLE and update last_grant.
REQ-025 Requests SHALL NOT be sampled in ACCESS or RESP; minimum occupancy SHALL be 3 cycles per legal access and 2 per illegal one.
REQ-026 A port whose p_req is withdrawn before ack SHALL still be completed; no cancellation is supported.
REQ-027 read and write SHALL never both be high, and both SHALL be 0 outside ACCESS.

Reset
REQ-028 While reset=0, the block SHALL be in IDLE, with read=write=0, address=0, writedata=0, byteenable=0, p_ack=0, p_err=0, p_rdata=0, stall counter=0 and last_grant=N_PORTS-1.
REQ-029 Reset asserted mid-ACCESS SHALL immediately drop read/write; the aborted transaction SHALL NOT be acked after release.
REQ-030 The first grant after reset SHALL go to port 0 when several ports request.

Verification
REQ-031 Port1 read, size=00, sign=1, addr=0x1003, readdata=0x80FF_FF11, waitrequest=0 -> address=0x1000, byteenable=1000, p_rdata=0xFFFF_FF80, p_ack=2'b10 on cycle 3.
REQ-032 Port0 write half 0x0000_ABCD to 0x2002, waitrequest high 4 cycles -> writedata=0xABCD_ABCD, byteenable=1100, write held 5 cycles, p_ack=01 with p_err=0.
REQ-033 Both ports requesting continuously after reset -> grants alternate 0,1,0,1; no port is acked twice in a row.
REQ-034 Port0 word read at 0x0000_0006 -> no read strobe, p_ack=01 with p_err=1 two cycles after request.
REQ-035 TIMEOUT=4, waitrequest stuck at 1 -> read drops after 4 stalled edges; p_ack with p_err=1 and p_rdata=0.
REQ-036 Reset pulsed during ACCESS -> outputs at reset values asynchronously; no p_ack follows release.
